mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter onto one single-port word memory
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [3:0]        d_wstrb,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  output logic              mem_we
);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_READ, RMW_WRITE} state_e;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_e            state_q;
  logic              port_d_q;     // 1 = data port owns the current transaction
  logic              last_d_q;     // 1 = data port was granted most recently
  logic              we_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic              i_rvalid_q, d_rvalid_q;
  logic [31:0]       i_rdata_q, d_rdata_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [31:0]       mem_data_in_q;
  logic              mem_we_q;

  logic              idle;
  logic              partial;
  logic [ADDR_W-1:0] gnt_addr_d;
  logic              gnt_full_d;
  logic [31:0]       merged_d;

  // Grants are decided only in IDLE; on contention the port not served last wins.
  assign idle  = resetn && (state_q == IDLE);
  assign i_gnt = idle && i_req && (!d_req || last_d_q);
  assign d_gnt = idle && d_req && !i_gnt;

  assign partial = we_q && (wstrb_q != 4'b1111) && (wstrb_q != 4'b0000);

  assign i_rvalid    = i_rvalid_q;
  assign d_rvalid    = d_rvalid_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_we      = mem_we_q;

  // Word-aligned address of the winning request and whether it is a full-word store.
  always_comb begin
    gnt_addr_d = (d_gnt ? d_addr : i_addr) & WORD_MASK;
    gnt_full_d = d_gnt && d_we && (d_wstrb == 4'b1111);
  end

  // Byte-lane merge of the store data over the old word read in RMW_READ.
  always_comb begin
    merged_d = mem_data_out;
    for (int k = 0; k < 4; k++) begin
      if (wstrb_q[k]) merged_d[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  // Transaction FSM; all memory-side and response outputs are registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      port_d_q      <= 1'b0;
      last_d_q      <= 1'b1;
      we_q          <= 1'b0;
      wstrb_q       <= 4'b0000;
      wdata_q       <= 32'h0;
      i_rvalid_q    <= 1'b0;
      d_rvalid_q    <= 1'b0;
      i_rdata_q     <= 32'h0;
      d_rdata_q     <= 32'h0;
      mem_address_q <= '0;
      mem_data_in_q <= 32'h0;
      mem_we_q      <= 1'b0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_gnt || d_gnt) begin
            port_d_q      <= d_gnt;
            last_d_q      <= d_gnt;
            we_q          <= d_gnt && d_we;
            wstrb_q       <= d_gnt ? d_wstrb : 4'b0000;
            wdata_q       <= d_gnt ? d_wdata : 32'h0;
            mem_address_q <= gnt_addr_d;
            mem_we_q      <= gnt_full_d;
            mem_data_in_q <= gnt_full_d ? d_wdata : 32'h0;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_q      <= 1'b0;
          mem_data_in_q <= 32'h0;
          if (partial) begin
            state_q <= RMW_READ;
          end else begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            if (port_d_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= we_q ? 32'h0 : mem_data_out;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= mem_data_out;
            end
          end
        end
        RMW_READ: begin
          mem_we_q      <= 1'b1;
          mem_data_in_q <= merged_d;
          state_q       <= RMW_WRITE;
        end
        RMW_WRITE: begin
          mem_we_q      <= 1'b0;
          mem_data_in_q <= 32'h0;
          mem_address_q <= '0;
          d_rvalid_q    <= 1'b1;
          d_rdata_q     <= 32'h0;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
